// File: rtl/pin_entry_requester_if.sv
// Authenticator-side bus between the PIN entry requester and the account authenticator.
// The requester drives the request and its operands; the authenticator answers with a result strobe.
interface pin_entry_requester_if;
    logic        auth_req;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        auth_ack;
    logic        acc_found;
    logic        acc_auth;

    modport master (
        output auth_req, acc_num, pin,
        input  auth_ack, acc_found, acc_auth
    );

    modport slave (
        input  auth_req, acc_num, pin,
        output auth_ack, acc_found, acc_auth
    );
endinterface

// File: rtl/pin_entry_requester.sv
// Card-session PIN collector: gathers four BCD keypresses into a binary PIN, asks the
// authenticator once per attempt, and tracks retries, timeouts and card lock.
module pin_entry_requester #(
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned ENTRY_TIMEOUT = 1000,
    parameter int unsigned RESP_TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   card_valid,
    input  logic [3:0]             acc_num_in,
    input  logic                   digit_valid,
    input  logic [3:0]             digit,
    input  logic                   clear_key,
    input  logic                   cancel,
    pin_entry_requester_if.master  auth,
    output logic                   grant,
    output logic                   deny,
    output logic                   card_locked,
    output logic [1:0]             retries_left,
    output logic [2:0]             digit_count,
    output logic                   busy
);

    localparam int ENT_W = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
    localparam int RSP_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [ENT_W-1:0] ENT_LAST = ENT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [RSP_W-1:0] RSP_LAST = RSP_W'(RESP_TIMEOUT - 1);
    localparam logic [1:0]       TRIES    = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE, COLLECT, REQUEST, WAIT_RESP, GRANTED, LOCKED
    } state_t;

    state_t           state;
    logic [15:0]      pin_acc;
    logic [ENT_W-1:0] idle_cnt;
    logic [RSP_W-1:0] resp_cnt;

    // Most-significant digit first: each new key shifts the decimal value left one place.
    function automatic logic [15:0] pin_shift(input logic [15:0] acc, input logic [3:0] d);
        return (acc * 16'd10) + {12'd0, d};
    endfunction

    assign busy        = (state != IDLE);
    assign card_locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            auth.auth_req <= 1'b0;
            auth.acc_num  <= 4'd0;
            auth.pin      <= 16'd0;
            grant         <= 1'b0;
            deny          <= 1'b0;
            retries_left  <= 2'd0;
            digit_count   <= 3'd0;
            pin_acc       <= 16'd0;
            idle_cnt      <= '0;
            resp_cnt      <= '0;
        end else begin
            grant         <= 1'b0;
            deny          <= 1'b0;
            auth.auth_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (card_valid) begin
                        auth.acc_num <= acc_num_in;
                        pin_acc      <= 16'd0;
                        digit_count  <= 3'd0;
                        retries_left <= TRIES;
                        idle_cnt     <= '0;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel || !card_valid) begin
                        pin_acc     <= 16'd0;
                        digit_count <= 3'd0;
                        state       <= IDLE;
                    end else if (clear_key) begin
                        pin_acc     <= 16'd0;
                        digit_count <= 3'd0;
                        idle_cnt    <= '0;
                    end else if (digit_count == 3'd4) begin
                        auth.pin      <= pin_acc;
                        auth.auth_req <= 1'b1;
                        state         <= REQUEST;
                    end else if (digit_valid) begin
                        // Any keypress restarts the idle timer, even a non-BCD one.
                        idle_cnt <= '0;
                        if (digit <= 4'd9) begin
                            pin_acc     <= pin_shift(pin_acc, digit);
                            digit_count <= digit_count + 3'd1;
                        end
                    end else if (idle_cnt == ENT_LAST) begin
                        pin_acc     <= 16'd0;
                        digit_count <= 3'd0;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                REQUEST: begin
                    if (cancel || !card_valid) begin
                        auth.pin    <= 16'd0;
                        pin_acc     <= 16'd0;
                        digit_count <= 3'd0;
                        state       <= IDLE;
                    end else begin
                        resp_cnt <= '0;
                        state    <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // Abort outranks a same-cycle response so no verdict escapes.
                    if (cancel || !card_valid) begin
                        auth.pin    <= 16'd0;
                        pin_acc     <= 16'd0;
                        digit_count <= 3'd0;
                        state       <= IDLE;
                    end else if (auth.auth_ack) begin
                        auth.pin    <= 16'd0;
                        pin_acc     <= 16'd0;
                        digit_count <= 3'd0;
                        idle_cnt    <= '0;
                        if (auth.acc_found && auth.acc_auth) begin
                            grant <= 1'b1;
                            state <= GRANTED;
                        end else if (!auth.acc_found) begin
                            deny  <= 1'b1;
                            state <= LOCKED;
                        end else begin
                            deny         <= 1'b1;
                            retries_left <= retries_left - 2'd1;
                            state        <= (retries_left == 2'd1) ? LOCKED : COLLECT;
                        end
                    end else if (resp_cnt == RSP_LAST) begin
                        deny        <= 1'b1;
                        auth.pin    <= 16'd0;
                        pin_acc     <= 16'd0;
                        digit_count <= 3'd0;
                        idle_cnt    <= '0;
                        state       <= COLLECT;
                    end else begin
                        resp_cnt <= resp_cnt + 1'b1;
                    end
                end
                GRANTED: if (!card_valid) state <= IDLE;
                LOCKED:  if (!card_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pin_entry_requester.md
PIN_ENTRY_REQUESTER -- requirements
Module: pin_entry_requester

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3, meaning failed attempts allowed before lock.
REQ-002 SHALL have parameter ENTRY_TIMEOUT, default 1000, meaning idle cycles allowed between keypresses in COLLECT.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 16, meaning cycles allowed for auth_ack after auth_req.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: clk (in, 1, rising-edge clock), rst_n (in, 1, asynchronous active-low reset).
REQ-005 SHALL have these session-control inputs:
- card_valid (in, 1): card present; acc_num_in valid while high.
- acc_num_in (in, 4): account number from the card.
REQ-006 SHALL have these keypad inputs:
- digit_valid (in, 1): one-cycle keypress strobe.
- digit (in, 4): BCD 0-9.
- clear_key (in, 1): erase entry.
- cancel (in, 1): abort session.
REQ-007 SHALL have these authenticator-side ports:
- auth_req (out, 1): request level.
- acc_num (out, 4): account number.
- pin (out, 16): binary PIN.
- auth_ack (in, 1): result strobe.
- acc_found (in, 1): account found.
- acc_auth (in, 1): PIN authenticated.
REQ-008 SHALL have these status outputs:
- grant (out, 1): one-cycle pulse.
- deny (out, 1): one-cycle pulse.
- card_locked (out, 1): level.
- retries_left (out, 2).
- digit_count (out, 3).
- busy (out, 1): high in any state other than IDLE.

Function
REQ-009 SHALL implement the states IDLE, COLLECT, REQUEST, WAIT_RESP, GRANTED and LOCKED.
REQ-010 In IDLE, when card_valid=1, SHALL latch acc_num_in into acc_num, clear pin and digit_count, load retries_left=MAX_TRIES, and go to COLLECT on the next cycle.
REQ-011 In COLLECT, on digit_valid with digit<=9 and digit_count<4, SHALL set pin <= pin*10 + digit (16-bit binary accumulation, most-significant digit first) and increment digit_count.
REQ-012 SHALL ignore digit_valid with digit>9, and SHALL ignore digit_valid when digit_count=4.
REQ-013 SHALL clear pin and digit_count on clear_key; if clear_key and digit_valid occur in the same cycle, clear wins and the digit is dropped.
REQ-014 SHALL transition COLLECT->REQUEST in the cycle after digit_count reaches 4.
REQ-015 In REQUEST, SHALL assert auth_req for exactly one cycle with acc_num and pin stable, then go to WAIT_RESP; acc_num and pin SHALL hold until the response is taken.
REQ-016 In WAIT_RESP, SHALL sample acc_found and acc_auth on auth_ack; the 1-cycle-later auth_ack is the minimum accepted latency.
REQ-017 If acc_found=1 and acc_auth=1, SHALL go to GRANTED, pulse grant in the cycle of entry, and hold GRANTED until card_valid=0, then go to IDLE.
REQ-018 If acc_found=0, SHALL pulse deny and go directly to LOCKED, without consuming retries.
REQ-019 If acc_found=1 and acc_auth=0, SHALL pulse deny and decrement retries_left.
- If the result is 0, SHALL go to LOCKED.
- Otherwise SHALL clear pin and digit_count and return to COLLECT.
REQ-020 If auth_ack is absent for RESP_TIMEOUT cycles in WAIT_RESP, SHALL pulse deny and return to COLLECT with pin cleared; retries_left SHALL be unchanged.
REQ-021 If no digit_valid or clear_key occurs for ENTRY_TIMEOUT consecutive cycles in COLLECT, SHALL clear pin and digit_count and return to IDLE.
REQ-022 SHALL return to IDLE on cancel or card_valid=0 in COLLECT, REQUEST or WAIT_RESP, clearing pin and digit_count.
- Cancel takes priority over auth_ack in the same cycle; no grant or deny is issued.
REQ-023 In LOCKED, SHALL hold card_locked=1, ignore all keypad inputs, and leave only when card_valid=0, then enter IDLE.
REQ-024 grant and deny SHALL never be asserted in the same cycle.
REQ-025 pin SHALL be driven to 0 whenever the block is not in REQUEST or WAIT_RESP.

Reset
REQ-026 On rst_n=0, at any time and asynchronously, SHALL force:
- state to IDLE;
- auth_req, grant, deny, card_locked and busy to 0;
- pin, acc_num and digit_count to 0;
- retries_left to 0.
REQ-027 SHALL discard a reset asserted mid-session, including in WAIT_RESP; a late auth_ack after reset release SHALL be ignored in IDLE.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- card_valid with acc_num_in=5, then keys 1,2,3,4, then auth_ack with found=1 and auth=1 -> pin=1234 (0x04D2) while auth_req is high, grant pulses once, busy=1 until card_valid=0.
- Keys 9,9 then clear_key then 0,0,0,7 -> pin=7 at request, digit_count sequence 1,2,0,1,2,3,4.
- Three requests each answered with found=1 and auth=0 -> retries_left steps 3,2,1,0, three deny pulses, card_locked=1, and further keys are ignored.
- A request answered with found=0 -> a single deny, card_locked=1, and retries_left still 3.
- No auth_ack for 16 cycles -> deny pulse, return to COLLECT, retries_left unchanged; then rst_n=0 mid-WAIT_RESP -> all outputs 0 immediately, asynchronously.
- cancel in the same cycle as auth_ack -> no grant or deny, state IDLE.
